// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 reader: FSM encoding, default timing
// constants and byte positions inside the 40-bit sensor frame.
package dht11_pkg;

    typedef enum logic [3:0] {
        OCIOSO       = 4'd0,
        INICIO_BAIXO = 4'd1,
        LIBERA       = 4'd2,
        RESP_BAIXO   = 4'd3,
        RESP_ALTO    = 4'd4,
        BIT_BAIXO    = 4'd5,
        BIT_ALTO     = 4'd6,
        VERIFICA     = 4'd7,
        PRONTO       = 4'd8,
        ERRO         = 4'd9
    } estado_t;

    localparam int CLK_FREQ_HZ_PADRAO   = 50_000_000;
    localparam int START_LOW_US_PADRAO  = 18000;
    localparam int BIT_THRESH_US_PADRAO = 40;
    localparam int TIMEOUT_US_PADRAO    = 100;

    localparam int FRAME_BITS = 40;

    // Byte k of the frame occupies bits [8k+7:8k]; byte 4 is sent first.
    localparam int BYTE_UMID_INT = 4;
    localparam int BYTE_UMID_DEC = 3;
    localparam int BYTE_TEMP_INT = 2;
    localparam int BYTE_TEMP_DEC = 1;
    localparam int BYTE_CHECKSUM = 0;

    function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame, input int idx);
        return frame[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/gerador_tick_us.sv
// Free-running 1 us tick: one-cycle pulse every CLK_FREQ_HZ/1e6 clocks
// (constantly high when the clock itself runs at 1 MHz).
module gerador_tick_us #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int DIVISOR = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
    localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ULTIMO) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == ULTIMO);

endmodule

// File: rtl/dht11_leitor.sv
// DHT11 single-wire reader: drives the start pulse, times the sensor response
// and 40 data bits, checks the checksum and presents the reading with a strobe.
module dht11_leitor
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = CLK_FREQ_HZ_PADRAO,
    parameter int START_LOW_US  = START_LOW_US_PADRAO,
    parameter int BIT_THRESH_US = BIT_THRESH_US_PADRAO,
    parameter int TIMEOUT_US    = TIMEOUT_US_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       dht11_in,
    output logic       dht11_drive_low,
    output logic [7:0] umidadeInteira,
    output logic [7:0] umidadeDecimal,
    output logic [7:0] temperaturaInteira,
    output logic [7:0] temperaturaDecimal,
    output logic       dadosProntos,
    output logic       erro,
    output logic       ocupado,
    output logic [3:0] estado_dbg
);

    // Limits are applied on the tick that would complete the last microsecond.
    localparam logic [15:0] START_FIM   = 16'(START_LOW_US - 1);
    localparam logic [15:0] TIMEOUT_FIM = 16'(TIMEOUT_US - 1);
    localparam logic [15:0] LIMIAR      = 16'(BIT_THRESH_US);

    logic tick;

    gerador_tick_us #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    estado_t               estado_q, estado_d;
    logic [1:0]            sync_q, sync_d;
    logic                  linha_ant_q, linha_ant_d;
    logic [15:0]           us_q, us_d;
    logic [FRAME_BITS-1:0] bits_q, bits_d;
    logic [5:0]            nbits_q, nbits_d;
    logic [7:0]            umid_int_q, umid_int_d;
    logic [7:0]            umid_dec_q, umid_dec_d;
    logic [7:0]            temp_int_q, temp_int_d;
    logic [7:0]            temp_dec_q, temp_dec_d;
    logic                  pronto_q, pronto_d;
    logic                  erro_q, erro_d;
    logic                  subida, descida;
    logic [7:0]            soma;

    assign subida  =  sync_q[1] & ~linha_ant_q;
    assign descida = ~sync_q[1] &  linha_ant_q;

    assign soma = frame_byte(bits_q, BYTE_UMID_INT) + frame_byte(bits_q, BYTE_UMID_DEC)
                + frame_byte(bits_q, BYTE_TEMP_INT) + frame_byte(bits_q, BYTE_TEMP_DEC);

    always_comb begin
        estado_d    = estado_q;
        sync_d      = {sync_q[0], dht11_in};
        linha_ant_d = sync_q[1];
        bits_d      = bits_q;
        nbits_d     = nbits_q;
        umid_int_d  = umid_int_q;
        umid_dec_d  = umid_dec_q;
        temp_int_d  = temp_int_q;
        temp_dec_d  = temp_dec_q;
        pronto_d    = 1'b0;
        erro_d      = erro_q;

        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    estado_d = INICIO_BAIXO;
                    erro_d   = 1'b0;
                    bits_d   = '0;
                    nbits_d  = '0;
                end
            end
            INICIO_BAIXO: if (tick && us_q >= START_FIM) estado_d = LIBERA;
            LIBERA:       if (descida) estado_d = RESP_BAIXO;
            RESP_BAIXO:   if (subida)  estado_d = RESP_ALTO;
            RESP_ALTO:    if (descida) estado_d = BIT_BAIXO;
            BIT_BAIXO:    if (subida)  estado_d = BIT_ALTO;
            BIT_ALTO: begin
                // The high-phase length decides the bit value, MSB first.
                if (descida) begin
                    bits_d   = {bits_q[FRAME_BITS-2:0], (us_q > LIMIAR)};
                    nbits_d  = nbits_q + 6'd1;
                    estado_d = (nbits_q == 6'd39) ? VERIFICA : BIT_BAIXO;
                end
            end
            VERIFICA: begin
                if (soma == frame_byte(bits_q, BYTE_CHECKSUM)) begin
                    estado_d   = PRONTO;
                    pronto_d   = 1'b1;
                    umid_int_d = frame_byte(bits_q, BYTE_UMID_INT);
                    umid_dec_d = frame_byte(bits_q, BYTE_UMID_DEC);
                    temp_int_d = frame_byte(bits_q, BYTE_TEMP_INT);
                    temp_dec_d = frame_byte(bits_q, BYTE_TEMP_DEC);
                end else begin
                    estado_d = ERRO;
                end
            end
            PRONTO: estado_d = OCIOSO;
            ERRO: begin
                erro_d   = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase

        // A line edge seen in the same cycle takes precedence over the timeout.
        if ((estado_q inside {LIBERA, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO})
            && estado_d == estado_q && tick && us_q >= TIMEOUT_FIM) begin
            estado_d = ERRO;
        end

        if (estado_d != estado_q) begin
            us_d = '0;
        end else if (tick && us_q != 16'hFFFF) begin
            us_d = us_q + 16'd1;
        end else begin
            us_d = us_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            sync_q      <= 2'b11;
            linha_ant_q <= 1'b1;
            us_q        <= '0;
            bits_q      <= '0;
            nbits_q     <= '0;
            umid_int_q  <= '0;
            umid_dec_q  <= '0;
            temp_int_q  <= '0;
            temp_dec_q  <= '0;
            pronto_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            sync_q      <= sync_d;
            linha_ant_q <= linha_ant_d;
            us_q        <= us_d;
            bits_q      <= bits_d;
            nbits_q     <= nbits_d;
            umid_int_q  <= umid_int_d;
            umid_dec_q  <= umid_dec_d;
            temp_int_q  <= temp_int_d;
            temp_dec_q  <= temp_dec_d;
            pronto_q    <= pronto_d;
            erro_q      <= erro_d;
        end
    end

    assign dht11_drive_low    = (estado_q == INICIO_BAIXO);
    assign ocupado            = (estado_q != OCIOSO);
    assign dadosProntos       = pronto_q;
    assign erro               = erro_q;
    assign umidadeInteira     = umid_int_q;
    assign umidadeDecimal     = umid_dec_q;
    assign temperaturaInteira = temp_int_q;
    assign temperaturaDecimal = temp_dec_q;
    assign estado_dbg         = estado_q;

endmodule

// File: tb/tb_dht11_leitor.sv
// Bench for dht11_leitor: a behavioural DHT11 drives the line, a frame-level
// model predicts strobe, error flag and output bytes for every read.
module tb_dht11_leitor;

    typedef logic [7:0] frame_t [5];

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       sensor_line = 1'b1;
    wire        dht11_in;
    logic       dht11_drive_low;
    logic [7:0] umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal;
    logic       dadosProntos, erro, ocupado;
    logic [3:0] estado_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    // Monitor: count strobes, flag any strobe longer than one cycle, capture data.
    int          strobe_cnt = 0;
    int          strobe_wide = 0;
    logic        strobe_prev = 1'b0;
    logic [31:0] cap_data = '0;

    // Frame-level expectation for the most recent read.
    logic [31:0] exp_data = '0;
    int          exp_strobes = 0;
    logic        exp_erro = 1'b0;

    logic seen_drive, seen_ocup;

    always #5 clock = ~clock;

    // Open-drain line: the host pulls low, otherwise the sensor (or pull-up) sets the level.
    assign dht11_in = dht11_drive_low ? 1'b0 : sensor_line;

    dht11_leitor #(
        .CLK_FREQ_HZ  (1_000_000),
        .START_LOW_US (100),
        .BIT_THRESH_US(40),
        .TIMEOUT_US   (100)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .iniciar           (iniciar),
        .dht11_in          (dht11_in),
        .dht11_drive_low   (dht11_drive_low),
        .umidadeInteira    (umidadeInteira),
        .umidadeDecimal    (umidadeDecimal),
        .temperaturaInteira(temperaturaInteira),
        .temperaturaDecimal(temperaturaDecimal),
        .dadosProntos      (dadosProntos),
        .erro              (erro),
        .ocupado           (ocupado),
        .estado_dbg        (estado_dbg)
    );

    always @(negedge clock) begin
        if (dadosProntos) begin
            strobe_cnt = strobe_cnt + 1;
            cap_data   = {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal};
            if (strobe_prev) strobe_wide = strobe_wide + 1;
        end
        strobe_prev = dadosProntos;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input logic lvl, input int n);
        sensor_line = lvl;
        repeat (n) step();
    endtask

    // Pulses iniciar for one cycle; reports the first sampled outputs and the
    // number of cycles the host held the line low.
    task automatic start_read(output int low_cycles, output logic d0, output logic o0, output logic e0);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        d0 = dht11_drive_low;
        o0 = ocupado;
        e0 = erro;
        low_cycles = 0;
        while (dht11_drive_low && low_cycles < 20000) begin
            low_cycles++;
            step();
        end
    endtask

    // Sensor reply. stuck_bit holds the line high 150 us in that bit (optionally
    // pulsing iniciar halfway); reset_bit asserts reset at that bit's rising edge.
    task automatic send_frame(input frame_t b, input int stuck_bit, input int reset_bit,
                              input bit pulse_iniciar);
        hold(1'b1, 20);
        hold(1'b0, 80);
        hold(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            logic v;
            v = b[i / 8][7 - (i % 8)];
            hold(1'b0, $urandom_range(45, 52));
            if (i == reset_bit) begin
                sensor_line = 1'b1;
                reset = 1'b1;
                step();
                seen_drive = dht11_drive_low;
                seen_ocup  = ocupado;
                reset = 1'b0;
                hold(1'b1, 30);
                return;
            end
            if (i == stuck_bit) begin
                hold(1'b1, 75);
                if (pulse_iniciar) begin
                    iniciar = 1'b1;
                    step();
                    iniciar = 1'b0;
                end
                hold(1'b1, 75);
                return;
            end
            hold(1'b1, v ? $urandom_range(55, 75) : $urandom_range(15, 30));
        end
        hold(1'b0, 50);
        sensor_line = 1'b1;
    endtask

    task automatic wait_idle(output logic timed_out);
        int n;
        n = 0;
        while (ocupado && n < 500) begin
            n++;
            step();
        end
        timed_out = ocupado;
    endtask

    // Reference model: checksum is the sum of the four data bytes modulo 256.
    task automatic model_read(input frame_t b);
        int s;
        s = (int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3])) % 256;
        if (s == int'(b[4])) begin
            exp_strobes = 1;
            exp_erro    = 1'b0;
            exp_data    = {b[0], b[1], b[2], b[3]};
        end else begin
            exp_strobes = 0;
            exp_erro    = 1'b1;
        end
    endtask

    function automatic frame_t valid_frame(input logic [7:0] a, input logic [7:0] c,
                                           input logic [7:0] d, input logic [7:0] e);
        frame_t f;
        f[0] = a; f[1] = c; f[2] = d; f[3] = e;
        f[4] = 8'((int'(a) + int'(c) + int'(d) + int'(e)) % 256);
        return f;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        iniciar = 1'b0;
        sensor_line = 1'b1;
        repeat (3) step();
        tests_run++;
        if ({dht11_drive_low, dadosProntos, erro, ocupado} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got drive/pronto/erro/ocupado=%b want 0000",
                     {dht11_drive_low, dadosProntos, erro, ocupado});
        end
        tests_run++;
        if ({umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal} !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %08h want 00000000",
                     {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_valid_read();
        frame_t f;
        int low, s0;
        logic d0, o0, e0, to;
        f[0] = 8'h2D; f[1] = 8'h00; f[2] = 8'h19; f[3] = 8'h05; f[4] = 8'h4B;
        model_read(f);
        s0 = strobe_cnt;
        start_read(low, d0, o0, e0);
        tests_run++;
        if ({d0, o0} !== 2'b11) begin
            tests_failed++;
            $display("FAIL start_latency: got drive/ocupado=%b want 11", {d0, o0});
        end
        tests_run++;
        if (low != 100) begin
            tests_failed++;
            $display("FAIL start_pulse_len: got %0d cycles want 100", low);
        end
        send_frame(f, -1, -1, 1'b0);
        wait_idle(to);
        tests_run++;
        if (to !== 1'b0 || strobe_cnt - s0 != 1 || strobe_wide != 0) begin
            tests_failed++;
            $display("FAIL valid_strobe: got strobes=%0d wide=%0d timeout=%b want 1 0 0",
                     strobe_cnt - s0, strobe_wide, to);
        end
        tests_run++;
        if (cap_data !== 32'h2D00_1905 || exp_data !== 32'h2D00_1905) begin
            tests_failed++;
            $display("FAIL valid_data_at_strobe: got %08h want 2d001905", cap_data);
        end
        tests_run++;
        if ({umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal, erro}
            !== {8'd45, 8'd0, 8'd25, 8'd5, 1'b0}) begin
            tests_failed++;
            $display("FAIL valid_outputs: got %0d %0d %0d %0d erro=%b want 45 0 25 5 erro=0",
                     umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal, erro);
        end
    endtask

    task automatic test_bad_checksum();
        frame_t f;
        int low, s0;
        logic d0, o0, e0, to;
        f[0] = 8'h2D; f[1] = 8'h00; f[2] = 8'h19; f[3] = 8'h05; f[4] = 8'h4C;
        model_read(f);
        s0 = strobe_cnt;
        start_read(low, d0, o0, e0);
        send_frame(f, -1, -1, 1'b0);
        wait_idle(to);
        tests_run++;
        if (erro !== exp_erro || strobe_cnt - s0 != exp_strobes || to !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_checksum_flag: got erro=%b strobes=%0d timeout=%b want erro=1 strobes=0",
                     erro, strobe_cnt - s0, to);
        end
        tests_run++;
        if ({umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal} !== exp_data) begin
            tests_failed++;
            $display("FAIL bad_checksum_keep: got %08h want %08h",
                     {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal}, exp_data);
        end
    endtask

    task automatic test_no_sensor();
        int low, n;
        logic d0, o0, e0;
        sensor_line = 1'b1;
        start_read(low, d0, o0, e0);
        tests_run++;
        if (e0 !== 1'b0 || low != 100) begin
            tests_failed++;
            $display("FAIL no_sensor_start: got erro=%b low=%0d want erro=0 low=100", e0, low);
        end
        n = 0;
        while (!erro && n < 300) begin
            step();
            n++;
        end
        tests_run++;
        if (n < 100 || n > 102) begin
            tests_failed++;
            $display("FAIL no_sensor_timeout: got erro after %0d cycles want 100..102", n);
        end
        tests_run++;
        if ({erro, ocupado, dht11_drive_low} !== 3'b100) begin
            tests_failed++;
            $display("FAIL no_sensor_idle: got erro/ocupado/drive=%b want 100",
                     {erro, ocupado, dht11_drive_low});
        end
    endtask

    task automatic test_stuck_bit();
        frame_t f;
        int low, s0, bad;
        logic d0, o0, e0, to;
        f = valid_frame(8'd60, 8'd0, 8'd22, 8'd3);
        start_read(low, d0, o0, e0);
        send_frame(f, 17, -1, 1'b1);
        tests_run++;
        if ({erro, ocupado} !== 2'b10) begin
            tests_failed++;
            $display("FAIL stuck_bit_error: got erro/ocupado=%b want 10", {erro, ocupado});
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (dht11_drive_low || ocupado) bad++;
            step();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL stuck_bit_not_queued: got %0d busy cycles want 0", bad);
        end
        model_read(f);
        s0 = strobe_cnt;
        start_read(low, d0, o0, e0);
        tests_run++;
        if ({e0, d0, o0} !== 3'b011) begin
            tests_failed++;
            $display("FAIL stuck_bit_clear: got erro/drive/ocupado=%b want 011", {e0, d0, o0});
        end
        send_frame(f, -1, -1, 1'b0);
        wait_idle(to);
        tests_run++;
        if (strobe_cnt - s0 != 1 || erro !== 1'b0 ||
            {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal} !== exp_data) begin
            tests_failed++;
            $display("FAIL stuck_bit_recover: got strobes=%0d erro=%b data=%08h want 1 0 %08h",
                     strobe_cnt - s0, erro,
                     {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal}, exp_data);
        end
    endtask

    task automatic test_reset_mid();
        frame_t f;
        int low, s0;
        logic d0, o0, e0, to;
        f = valid_frame(8'd33, 8'd1, 8'd28, 8'd7);
        start_read(low, d0, o0, e0);
        send_frame(f, -1, 20, 1'b0);
        exp_data = '0;
        exp_erro = 1'b0;
        tests_run++;
        if ({seen_drive, seen_ocup} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mid_release: got drive/ocupado=%b want 00", {seen_drive, seen_ocup});
        end
        tests_run++;
        if ({umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal, erro, ocupado}
            !== {exp_data, exp_erro, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_cleared: got data=%08h erro=%b ocupado=%b want 00000000 0 0",
                     {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal}, erro, ocupado);
        end
        model_read(f);
        s0 = strobe_cnt;
        start_read(low, d0, o0, e0);
        send_frame(f, -1, -1, 1'b0);
        wait_idle(to);
        tests_run++;
        if (strobe_cnt - s0 != 1 ||
            {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal} !== exp_data) begin
            tests_failed++;
            $display("FAIL reset_mid_next_read: got strobes=%0d data=%08h want 1 %08h", strobe_cnt - s0,
                     {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal}, exp_data);
        end
    endtask

    task automatic test_back_to_back();
        frame_t f;
        int n, s0;
        logic to;
        f = valid_frame(8'd51, 8'd0, 8'd19, 8'd9);
        model_read(f);
        s0 = strobe_cnt;
        iniciar = 1'b1;
        step();
        n = 0;
        while (dht11_drive_low && n < 200) begin
            n++;
            step();
        end
        send_frame(f, -1, -1, 1'b0);
        wait_idle(to);
        step();
        tests_run++;
        if ({to, dht11_drive_low, ocupado} !== 3'b011 || strobe_cnt - s0 != 1) begin
            tests_failed++;
            $display("FAIL back_to_back_retrigger: got timeout/drive/ocupado=%b strobes=%0d want 011 1",
                     {to, dht11_drive_low, ocupado}, strobe_cnt - s0);
        end
        iniciar = 1'b0;
        f = valid_frame(8'd52, 8'd0, 8'd20, 8'd1);
        model_read(f);
        s0 = strobe_cnt;
        n = 0;
        while (dht11_drive_low && n < 200) begin
            n++;
            step();
        end
        send_frame(f, -1, -1, 1'b0);
        wait_idle(to);
        tests_run++;
        if (strobe_cnt - s0 != 1 ||
            {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal} !== exp_data) begin
            tests_failed++;
            $display("FAIL back_to_back_second: got strobes=%0d data=%08h want 1 %08h", strobe_cnt - s0,
                     {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal}, exp_data);
        end
    endtask

    task automatic test_random_reads();
        frame_t f;
        int low, s0, s;
        logic d0, o0, e0, to;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) f[j] = 8'($urandom_range(0, 255));
            s = (int'(f[0]) + int'(f[1]) + int'(f[2]) + int'(f[3])) % 256;
            if ($urandom_range(0, 1) == 1) f[4] = 8'(s);
            else f[4] = 8'((s + int'($urandom_range(1, 255))) % 256);
            model_read(f);
            s0 = strobe_cnt;
            start_read(low, d0, o0, e0);
            send_frame(f, -1, -1, 1'b0);
            wait_idle(to);
            tests_run++;
            if (strobe_cnt - s0 != exp_strobes || erro !== exp_erro || to !== 1'b0 || low != 100) begin
                tests_failed++;
                $display("FAIL random_%0d_flags: got strobes=%0d erro=%b timeout=%b low=%0d want %0d %b 0 100",
                         k, strobe_cnt - s0, erro, to, low, exp_strobes, exp_erro);
            end
            tests_run++;
            if ({umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal} !== exp_data) begin
                tests_failed++;
                $display("FAIL random_%0d_data: got %08h want %08h", k,
                         {umidadeInteira, umidadeDecimal, temperaturaInteira, temperaturaDecimal}, exp_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_read();
        test_bad_checksum();
        test_no_sensor();
        test_stuck_bit();
        test_reset_mid();
        test_back_to_back();
        test_random_reads();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
